// File: rtl/ct_had_dbginfo_reader.sv
// Host-side reader for the HAD dbgfifo2 debug-info snapshot: drains DBG_DEPTH words
// through a valid/ack holding register, drains the rest on abort, and flags torn snapshots.
module ct_had_dbginfo_reader #(
   parameter int DBG_WIDTH = 64,
   parameter int DBG_DEPTH = 6,
   parameter int CNT_WIDTH = 3
) (
   input  logic                 dbginfo_clk,
   input  logic                 cpurst_b,
   input  logic                 regs_dbgrd_start,
   input  logic                 regs_dbgrd_abort,
   input  logic                 regs_dbgrd_ack,
   input  logic                 had_dbg_ack_pc,
   input  logic [DBG_WIDTH-1:0] dbgfifo2_data,
   output logic                 dbgfifo2_read_ren,
   output logic [DBG_WIDTH-1:0] dbgrd_word,
   output logic                 dbgrd_vld,
   output logic [CNT_WIDTH-1:0] dbgrd_idx,
   output logic                 dbgrd_busy,
   output logic                 dbgrd_done,
   output logic                 dbgrd_aborted,
   output logic                 dbgrd_torn,
   output logic                 dbgrd_clk_en
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_HOLD,
      ST_DRAIN,
      ST_SETTLE
   } state_t;

   localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(DBG_DEPTH);
   localparam logic [CNT_WIDTH-1:0] LAST_C  = CNT_WIDTH'(DBG_DEPTH - 1);
   localparam logic [CNT_WIDTH-1:0] ONE_C   = CNT_WIDTH'(1);

   state_t               state, state_nxt;
   logic [CNT_WIDTH-1:0] rd_cnt;
   logic                 ack_f;
   logic                 start_acc;
   logic                 abort_acc;
   logic                 ack_acc;

   // Accepted events after priority: abort beats ack, and an abort in IDLE also masks start.
   assign start_acc = (state == ST_IDLE) & regs_dbgrd_start & ~regs_dbgrd_abort;
   assign abort_acc = regs_dbgrd_abort &
                      ((state == ST_REQ) | (state == ST_WAIT) | (state == ST_HOLD));
   assign ack_acc   = regs_dbgrd_ack & dbgrd_vld & ~abort_acc;

   // Pure decodes of registered state, so the FIFO strobe never glitches.
   assign dbgfifo2_read_ren = (state == ST_REQ) | ((state == ST_DRAIN) & (rd_cnt < DEPTH_C));
   assign dbgrd_busy        = (state != ST_IDLE);
   assign dbgrd_done        = (state == ST_SETTLE);
   assign dbgrd_clk_en      = regs_dbgrd_start | dbgrd_busy | had_dbg_ack_pc | ack_f;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (start_acc) state_nxt = ST_REQ;
         ST_REQ:    state_nxt = abort_acc ? ST_DRAIN : ST_WAIT;
         ST_WAIT:   state_nxt = abort_acc ? ST_DRAIN : ST_HOLD;
         ST_HOLD: begin
            if (abort_acc)    state_nxt = ST_DRAIN;
            else if (ack_acc) state_nxt = (dbgrd_idx == LAST_C) ? ST_SETTLE : ST_REQ;
         end
         // The read issued at rd_cnt==LAST_C is the final one; leave right after it.
         ST_DRAIN:  if (rd_cnt >= LAST_C) state_nxt = ST_SETTLE;
         ST_SETTLE: state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge dbginfo_clk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         state         <= ST_IDLE;
         rd_cnt        <= '0;
         dbgrd_word    <= '0;
         dbgrd_vld     <= 1'b0;
         dbgrd_idx     <= '0;
         dbgrd_aborted <= 1'b0;
         dbgrd_torn    <= 1'b0;
         ack_f         <= 1'b0;
      end else begin
         state <= state_nxt;
         ack_f <= had_dbg_ack_pc;

         if (start_acc)
            rd_cnt <= '0;
         else if (dbgfifo2_read_ren && (rd_cnt != DEPTH_C))
            rd_cnt <= rd_cnt + ONE_C;

         if (start_acc)
            dbgrd_idx <= '0;
         else if (ack_acc && (dbgrd_idx != LAST_C))
            dbgrd_idx <= dbgrd_idx + ONE_C;

         // An abort during WAIT drops the capture that would otherwise land.
         if ((state == ST_WAIT) && !abort_acc) begin
            dbgrd_word <= dbgfifo2_data;
            dbgrd_vld  <= 1'b1;
         end else if (abort_acc || ack_acc) begin
            dbgrd_vld  <= 1'b0;
         end

         if (start_acc)
            dbgrd_aborted <= 1'b0;
         else if (abort_acc)
            dbgrd_aborted <= 1'b1;

         if (start_acc)
            dbgrd_torn <= 1'b0;
         else if (had_dbg_ack_pc && !ack_f && dbgrd_busy)
            dbgrd_torn <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ct_had_dbginfo_reader.sv
// Directed bench for ct_had_dbginfo_reader with a small dbgfifo2 read-port model.
module tb_ct_had_dbginfo_reader;

   localparam logic [63:0] W_BASE = 64'h0123_4567_89AB_CDA0;

   logic        dbginfo_clk = 1'b0;
   logic        cpurst_b;
   logic        regs_dbgrd_start, regs_dbgrd_abort, regs_dbgrd_ack, had_dbg_ack_pc;
   logic [63:0] dbgfifo2_data;
   logic        dbgfifo2_read_ren;
   logic [63:0] dbgrd_word;
   logic        dbgrd_vld;
   logic [2:0]  dbgrd_idx;
   logic        dbgrd_busy, dbgrd_done, dbgrd_aborted, dbgrd_torn, dbgrd_clk_en;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   int ren_cnt;
   int fifo_ptr;
   logic [63:0] mem [6];

   always #5 dbginfo_clk = ~dbginfo_clk;

   ct_had_dbginfo_reader #(.DBG_WIDTH(64), .DBG_DEPTH(6), .CNT_WIDTH(3)) dut (
      .dbginfo_clk      (dbginfo_clk),
      .cpurst_b         (cpurst_b),
      .regs_dbgrd_start (regs_dbgrd_start),
      .regs_dbgrd_abort (regs_dbgrd_abort),
      .regs_dbgrd_ack   (regs_dbgrd_ack),
      .had_dbg_ack_pc   (had_dbg_ack_pc),
      .dbgfifo2_data    (dbgfifo2_data),
      .dbgfifo2_read_ren(dbgfifo2_read_ren),
      .dbgrd_word       (dbgrd_word),
      .dbgrd_vld        (dbgrd_vld),
      .dbgrd_idx        (dbgrd_idx),
      .dbgrd_busy       (dbgrd_busy),
      .dbgrd_done       (dbgrd_done),
      .dbgrd_aborted    (dbgrd_aborted),
      .dbgrd_torn       (dbgrd_torn),
      .dbgrd_clk_en     (dbgrd_clk_en)
   );

   // FIFO read port: data registered at the ren edge; pointer wraps once it reaches 6.
   always @(posedge dbginfo_clk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         fifo_ptr      <= 0;
         dbgfifo2_data <= '0;
         ren_cnt       <= 0;
      end else begin
         if (dbgfifo2_read_ren) begin
            ren_cnt       <= ren_cnt + 1;
            dbgfifo2_data <= (fifo_ptr < 6) ? mem[fifo_ptr] : 64'hDEAD_DEAD_DEAD_DEAD;
            fifo_ptr      <= fifo_ptr + 1;
         end else if (fifo_ptr >= 6) begin
            fifo_ptr <= 0;
         end
      end
   end

   task automatic step();
      @(posedge dbginfo_clk);
      #1;
      cyc++;
   endtask

   task automatic do_start();
      regs_dbgrd_start = 1'b1;
      step();
      regs_dbgrd_start = 1'b0;
   endtask

   task automatic ack_pulse();
      regs_dbgrd_ack = 1'b1;
      step();
      regs_dbgrd_ack = 1'b0;
   endtask

   task automatic wait_vld(output bit ok);
      int n = 0;
      while (!dbgrd_vld && n < 12) begin step(); n++; end
      ok = dbgrd_vld;
   endtask

   task automatic wait_done(output bit ok);
      int n = 0;
      while (!dbgrd_done && n < 40) begin step(); n++; end
      ok = dbgrd_done;
   endtask

   // Acks every remaining word until the FSM is back in IDLE.
   task automatic ack_rest(output bit ok);
      int n = 0;
      while (dbgrd_busy && n < 80) begin
         if (dbgrd_vld) ack_pulse();
         else step();
         n++;
      end
      ok = !dbgrd_busy;
   endtask

   task automatic test_reset();
      cpurst_b = 1'b0;
      regs_dbgrd_start = 0; regs_dbgrd_abort = 0; regs_dbgrd_ack = 0; had_dbg_ack_pc = 0;
      #23;
      n_cmp++; if (dbgfifo2_read_ren !== 1'b0) begin n_bad++; $display("FAIL reset_ren: got %b want 0", dbgfifo2_read_ren); end
      n_cmp++; if (dbgrd_word !== 64'h0) begin n_bad++; $display("FAIL reset_word: got %h want 0", dbgrd_word); end
      n_cmp++; if ({dbgrd_vld, dbgrd_busy, dbgrd_done, dbgrd_aborted, dbgrd_torn} !== 5'b0) begin
         n_bad++; $display("FAIL reset_flags: got %b want 00000", {dbgrd_vld, dbgrd_busy, dbgrd_done, dbgrd_aborted, dbgrd_torn}); end
      n_cmp++; if (dbgrd_idx !== 3'd0) begin n_bad++; $display("FAIL reset_idx: got %0d want 0", dbgrd_idx); end
      cpurst_b = 1'b1;
      step(); step();
   endtask

   task automatic test_full_readout();
      bit ok;
      int base = ren_cnt;
      cyc = 0;
      do_start();
      n_cmp++; if (dbgfifo2_read_ren !== 1'b1 || dbgrd_busy !== 1'b1) begin
         n_bad++; $display("FAIL full_req: got ren=%b busy=%b want 1 1", dbgfifo2_read_ren, dbgrd_busy); end
      for (int i = 0; i < 6; i++) begin
         wait_vld(ok);
         n_cmp++; if (!ok || cyc != 3 + 3 * i) begin n_bad++; $display("FAIL full_vld_cycle[%0d]: got cycle %0d vld=%b want cycle %0d", i, cyc, ok, 3 + 3 * i); end
         n_cmp++; if (dbgrd_idx !== 3'(i)) begin n_bad++; $display("FAIL full_idx[%0d]: got %0d want %0d", i, dbgrd_idx, i); end
         n_cmp++; if (dbgrd_word !== W_BASE + 64'(i)) begin n_bad++; $display("FAIL full_word[%0d]: got %h want %h", i, dbgrd_word, W_BASE + 64'(i)); end
         ack_pulse();
         if (i == 0) begin
            n_cmp++; if (dbgrd_vld !== 1'b0) begin n_bad++; $display("FAIL full_vld_clear: got %b want 0", dbgrd_vld); end
         end
      end
      n_cmp++; if (cyc != 19 || dbgrd_done !== 1'b1 || dbgrd_busy !== 1'b1) begin
         n_bad++; $display("FAIL full_settle: cycle %0d done=%b busy=%b want cycle 19 done=1 busy=1", cyc, dbgrd_done, dbgrd_busy); end
      step();
      n_cmp++; if (dbgrd_done !== 1'b0 || dbgrd_busy !== 1'b0) begin
         n_bad++; $display("FAIL full_idle: done=%b busy=%b want 0 0", dbgrd_done, dbgrd_busy); end
      n_cmp++; if (ren_cnt - base != 6) begin n_bad++; $display("FAIL full_ren_count: got %0d want 6", ren_cnt - base); end
      n_cmp++; if (dbgrd_aborted !== 1'b0 || dbgrd_torn !== 1'b0) begin
         n_bad++; $display("FAIL full_sticky: aborted=%b torn=%b want 0 0", dbgrd_aborted, dbgrd_torn); end
   endtask

   task automatic test_delayed_ack();
      bit ok;
      bit held_ok;
      int base = ren_cnt;
      int hold_base;
      do_start();
      for (int i = 0; i < 6; i++) begin
         wait_vld(ok);
         n_cmp++; if (!ok || dbgrd_word !== W_BASE + 64'(i)) begin n_bad++; $display("FAIL delay_word[%0d]: got %h want %h", i, dbgrd_word, W_BASE + 64'(i)); end
         if (i == 2) begin
            held_ok = 1'b1;
            hold_base = ren_cnt;
            repeat (10) begin
               step();
               if (dbgrd_vld !== 1'b1 || dbgrd_word !== W_BASE + 64'd2 || dbgfifo2_read_ren !== 1'b0) held_ok = 1'b0;
            end
            n_cmp++; if (!held_ok) begin n_bad++; $display("FAIL delay_hold: vld=%b word=%h want 1 %h", dbgrd_vld, dbgrd_word, W_BASE + 64'd2); end
            n_cmp++; if (ren_cnt != hold_base) begin n_bad++; $display("FAIL delay_no_ren: got %0d extra reads want 0", ren_cnt - hold_base); end
         end
         ack_pulse();
      end
      wait_done(ok);
      step();
      n_cmp++; if (!ok || ren_cnt - base != 6) begin n_bad++; $display("FAIL delay_total: done=%b ren=%0d want 1 6", ok, ren_cnt - base); end
   endtask

   task automatic test_abort_hold();
      bit ok;
      int base;
      int run = 0;
      do_start();
      wait_vld(ok); ack_pulse();
      wait_vld(ok);
      n_cmp++; if (dbgrd_idx !== 3'd1) begin n_bad++; $display("FAIL abh_idx: got %0d want 1", dbgrd_idx); end
      base = ren_cnt;
      regs_dbgrd_abort = 1'b1;
      step();
      regs_dbgrd_abort = 1'b0;
      n_cmp++; if (dbgrd_vld !== 1'b0 || dbgrd_aborted !== 1'b1) begin
         n_bad++; $display("FAIL abh_flags: vld=%b aborted=%b want 0 1", dbgrd_vld, dbgrd_aborted); end
      while (dbgfifo2_read_ren && run < 10) begin run++; step(); end
      n_cmp++; if (run != 4) begin n_bad++; $display("FAIL abh_drain_run: got %0d want 4", run); end
      wait_done(ok);
      n_cmp++; if (!ok || ren_cnt - base != 4) begin n_bad++; $display("FAIL abh_done: done=%b ren=%0d want 1 4", ok, ren_cnt - base); end
      step();
      n_cmp++; if (dbgrd_aborted !== 1'b1 || dbgrd_busy !== 1'b0) begin
         n_bad++; $display("FAIL abh_after: aborted=%b busy=%b want 1 0", dbgrd_aborted, dbgrd_busy); end
      do_start();
      wait_vld(ok);
      n_cmp++; if (dbgrd_word !== W_BASE || dbgrd_idx !== 3'd0) begin
         n_bad++; $display("FAIL abh_restart_w0: word=%h idx=%0d want %h 0", dbgrd_word, dbgrd_idx, W_BASE); end
      n_cmp++; if (dbgrd_aborted !== 1'b0) begin n_bad++; $display("FAIL abh_restart_clear: aborted=%b want 0", dbgrd_aborted); end
      ack_rest(ok);
   endtask

   task automatic test_abort_with_ack();
      bit ok;
      int base = ren_cnt;
      do_start();
      for (int i = 0; i < 3; i++) begin wait_vld(ok); ack_pulse(); end
      wait_vld(ok);
      regs_dbgrd_ack = 1'b1;
      regs_dbgrd_abort = 1'b1;
      step();
      regs_dbgrd_ack = 1'b0;
      regs_dbgrd_abort = 1'b0;
      n_cmp++; if (dbgrd_idx !== 3'd3 || dbgrd_vld !== 1'b0 || dbgrd_aborted !== 1'b1) begin
         n_bad++; $display("FAIL abk_state: idx=%0d vld=%b aborted=%b want 3 0 1", dbgrd_idx, dbgrd_vld, dbgrd_aborted); end
      wait_done(ok);
      step();
      n_cmp++; if (!ok || ren_cnt - base != 6) begin n_bad++; $display("FAIL abk_ren_total: done=%b ren=%0d want 1 6", ok, ren_cnt - base); end
   endtask

   task automatic test_torn();
      bit ok;
      do_start();
      for (int i = 0; i < 4; i++) begin wait_vld(ok); ack_pulse(); end
      had_dbg_ack_pc = 1'b1;
      step(); step();
      had_dbg_ack_pc = 1'b0;
      ack_rest(ok);
      n_cmp++; if (!ok || dbgrd_torn !== 1'b1 || dbgrd_aborted !== 1'b0) begin
         n_bad++; $display("FAIL torn_set: idle=%b torn=%b aborted=%b want 1 1 0", ok, dbgrd_torn, dbgrd_aborted); end
      do_start();
      n_cmp++; if (dbgrd_torn !== 1'b0) begin n_bad++; $display("FAIL torn_clear_on_start: got %b want 0", dbgrd_torn); end
      ack_rest(ok);
      had_dbg_ack_pc = 1'b1;
      step(); step();
      n_cmp++; if (dbgrd_torn !== 1'b0 || dbgrd_clk_en !== 1'b1) begin
         n_bad++; $display("FAIL torn_idle_rise: torn=%b clk_en=%b want 0 1", dbgrd_torn, dbgrd_clk_en); end
      had_dbg_ack_pc = 1'b0;
      step(); step(); step();
      n_cmp++; if (dbgrd_clk_en !== 1'b0) begin n_bad++; $display("FAIL clk_en_quiet: got %b want 0", dbgrd_clk_en); end
   endtask

   task automatic test_ignored_and_reset();
      int base;
      regs_dbgrd_start = 1'b1;
      regs_dbgrd_abort = 1'b1;
      step();
      regs_dbgrd_start = 1'b0;
      regs_dbgrd_abort = 1'b0;
      n_cmp++; if (dbgrd_busy !== 1'b0 || dbgfifo2_read_ren !== 1'b0) begin
         n_bad++; $display("FAIL start_abort_idle: busy=%b ren=%b want 0 0", dbgrd_busy, dbgfifo2_read_ren); end
      base = ren_cnt;
      do_start();
      regs_dbgrd_start = 1'b1;
      regs_dbgrd_ack = 1'b1;
      step();
      regs_dbgrd_start = 1'b0;
      regs_dbgrd_ack = 1'b0;
      step();
      n_cmp++; if (dbgrd_vld !== 1'b1 || dbgrd_idx !== 3'd0 || dbgrd_word !== W_BASE) begin
         n_bad++; $display("FAIL ignored_hold: vld=%b idx=%0d word=%h want 1 0 %h", dbgrd_vld, dbgrd_idx, dbgrd_word, W_BASE); end
      n_cmp++; if (ren_cnt - base != 1 || dbgfifo2_read_ren !== 1'b0) begin
         n_bad++; $display("FAIL ignored_ren: count=%0d ren=%b want 1 0", ren_cnt - base, dbgfifo2_read_ren); end
      #2 cpurst_b = 1'b0;
      #1;
      n_cmp++; if ({dbgrd_vld, dbgrd_busy, dbgrd_done, dbgrd_aborted, dbgrd_torn, dbgfifo2_read_ren} !== 6'b0) begin
         n_bad++; $display("FAIL midreset_flags: got %b want 000000", {dbgrd_vld, dbgrd_busy, dbgrd_done, dbgrd_aborted, dbgrd_torn, dbgfifo2_read_ren}); end
      n_cmp++; if (dbgrd_word !== 64'h0 || dbgrd_idx !== 3'd0) begin
         n_bad++; $display("FAIL midreset_data: word=%h idx=%0d want 0 0", dbgrd_word, dbgrd_idx); end
      step(); step();
      cpurst_b = 1'b1;
      step();
   endtask

   initial begin
      for (int i = 0; i < 6; i++) mem[i] = W_BASE + 64'(i);
      test_reset();
      test_full_readout();
      test_delayed_ack();
      test_abort_hold();
      test_abort_with_ack();
      test_torn();
      test_ignored_and_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
